// File: rtl/sprite_dma_pkg.sv
// Shared encodings for the sprite DMA: FSM states, register offsets and CTRL bit positions.
package sprite_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FETCH = 2'd2,
        ST_STORE = 2'd3
    } dma_state_t;

    localparam logic [1:0] OFF_SRC_HI = 2'd0;
    localparam logic [1:0] OFF_SRC_LO = 2'd1;
    localparam logic [1:0] OFF_LEN    = 2'd2;
    localparam logic [1:0] OFF_CTRL   = 2'd3;

    localparam int CTRL_GO      = 0;
    localparam int CTRL_GO_VB   = 1;
    localparam int CTRL_CLR_ERR = 7;

    function automatic logic [7:0] status_byte(input logic err, input logic armed, input logic busy);
        return {err, 5'b0, armed, busy};
    endfunction

endpackage

// File: rtl/sprite_dma.sv
// Work RAM -> sprite RAM block copier; borrows the wkram port from the CPU and stalls
// CPU wkram cycles via wait_n while it owns the port.
module sprite_dma
    import sprite_dma_pkg::*;
#(
    parameter int SRC_AW = 14,
    parameter int DST_AW = 7
) (
    input  logic              clk_24,
    input  logic              reset,
    input  logic              vblank,
    input  logic              reg_cs,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_wr_n,
    input  logic              cpu_mreq_n,
    input  logic              cpu_wkram_cs,
    input  logic [7:0]        wkram_q,
    output logic [7:0]        reg_rdata,
    output logic              cpu_wait_n,
    output logic [SRC_AW-1:0] wkram_addr,
    output logic              wkram_wr,
    output logic [DST_AW-1:0] spr_addr,
    output logic [7:0]        spr_data,
    output logic              spr_wr,
    output logic              busy
);

    dma_state_t  state, state_nx;
    logic        wr_n_q, vb_q;
    logic [13:0] src_r, src_w;
    logic [6:0]  len_r, len_w, idx;
    logic        err;
    logic        reg_wr, ctrl_wr, go, go_vb, vb_rise, start, owns;
    logic        unused;

    // One strobe per CPU write: act on the falling edge of the registered wr_n.
    assign reg_wr  = reg_cs && wr_n_q && !cpu_wr_n;
    assign ctrl_wr = reg_wr && (cpu_addr[1:0] == OFF_CTRL);
    assign go      = ctrl_wr && cpu_dout[CTRL_GO];
    assign go_vb   = ctrl_wr && cpu_dout[CTRL_GO_VB];
    assign vb_rise = vblank && !vb_q;
    assign unused  = ^cpu_addr[15:SRC_AW];

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    state_nx = ST_FETCH;
                    start    = 1'b1;
                end else if (go_vb) begin
                    state_nx = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (vb_rise) begin
                    state_nx = ST_FETCH;
                    start    = 1'b1;
                end
            end
            ST_FETCH: state_nx = ST_STORE;
            ST_STORE: state_nx = (idx == len_w) ? ST_IDLE : ST_FETCH;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            wr_n_q <= 1'b1;
            vb_q   <= 1'b0;
            src_r  <= '0;
            len_r  <= '0;
            src_w  <= '0;
            len_w  <= '0;
            idx    <= '0;
            err    <= 1'b0;
        end else begin
            wr_n_q <= cpu_wr_n;
            vb_q   <= vblank;
            if (reg_wr) begin
                case (cpu_addr[1:0])
                    OFF_SRC_HI: src_r[13:8] <= cpu_dout[5:0];
                    OFF_SRC_LO: src_r[7:0]  <= cpu_dout;
                    OFF_LEN:    len_r       <= cpu_dout[6:0];
                    default:    ;
                endcase
            end
            // Set wins over clear when both land in the same write.
            if (ctrl_wr) begin
                if (cpu_dout[CTRL_CLR_ERR]) err <= 1'b0;
                if ((go || go_vb) && state != ST_IDLE) err <= 1'b1;
            end
            // Working copy so register writes during a copy only affect the next one.
            if (start) begin
                src_w <= src_r;
                len_w <= len_r;
                idx   <= '0;
            end else if (state == ST_STORE) begin
                idx <= idx + 7'd1;
            end
        end
    end

    assign owns       = (state == ST_FETCH) || (state == ST_STORE);
    assign busy       = (state != ST_IDLE);
    assign cpu_wait_n = !(owns && cpu_wkram_cs && !cpu_mreq_n);
    assign wkram_addr = owns ? SRC_AW'(src_w + 14'(idx)) : cpu_addr[SRC_AW-1:0];
    assign wkram_wr   = !owns && cpu_wkram_cs && !cpu_mreq_n && !cpu_wr_n;
    assign spr_wr     = (state == ST_STORE);
    assign spr_addr   = spr_wr ? DST_AW'(idx) : '0;
    assign spr_data   = spr_wr ? wkram_q : 8'h00;
    assign reg_rdata  = (reg_cs && cpu_addr[1:0] == OFF_CTRL)
                      ? status_byte(err, state == ST_ARMED, busy) : 8'h00;

endmodule

// File: tb/tb_sprite_dma.sv
// Scoreboard bench for sprite_dma: stimulus pushes expected sprite writes, a monitor pops and compares.
module tb_sprite_dma;

    logic        clk_24, reset, vblank, reg_cs, cpu_wr_n, cpu_mreq_n, cpu_wkram_cs;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout, wkram_q, reg_rdata, spr_data;
    logic        cpu_wait_n, wkram_wr, spr_wr, busy;
    logic [13:0] wkram_addr;
    logic [6:0]  spr_addr;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n;

    logic [7:0] wk_mem [0:16383];

    sprite_dma #(.SRC_AW(14), .DST_AW(7)) dut (
        .clk_24(clk_24), .reset(reset), .vblank(vblank), .reg_cs(reg_cs),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_wr_n(cpu_wr_n),
        .cpu_mreq_n(cpu_mreq_n), .cpu_wkram_cs(cpu_wkram_cs), .wkram_q(wkram_q),
        .reg_rdata(reg_rdata), .cpu_wait_n(cpu_wait_n), .wkram_addr(wkram_addr),
        .wkram_wr(wkram_wr), .spr_addr(spr_addr), .spr_data(spr_data),
        .spr_wr(spr_wr), .busy(busy)
    );

    initial clk_24 = 1'b0;
    always #5 clk_24 = ~clk_24;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37) ^ (a >> 6) ^ 8'h5A);
    endfunction

    // wkram: single port, one clock read latency
    always @(posedge clk_24) begin
        if (wkram_wr) wk_mem[wkram_addr] <= cpu_dout;
        wkram_q <= wk_mem[wkram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_24) begin
        if (spr_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spr_unexpected actual addr=%0h data=%0h expected none", spr_addr, spr_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("spr_addr", 32'(spr_addr), 32'(mon_e.addr));
                chk("spr_data", 32'(spr_data), 32'(mon_e.data));
            end
        end
    end

    task automatic push_copy(input int src, input int len);
        exp_t e;
        for (int i = 0; i <= len; i++) begin
            e.addr = 7'(i);
            e.data = pat((src + i) & 16'h3FFF);
            exp_q.push_back(e);
        end
    endtask

    task automatic bus_idle();
        cpu_addr     = 16'h0000;
        cpu_dout     = 8'h00;
        reg_cs       = 1'b0;
        cpu_wr_n     = 1'b1;
        cpu_mreq_n   = 1'b1;
        cpu_wkram_cs = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] off, input logic [7:0] data);
        @(negedge clk_24);
        cpu_addr   = {14'h22C0, off};
        cpu_dout   = data;
        reg_cs     = 1'b1;
        cpu_mreq_n = 1'b0;
        cpu_wr_n   = 1'b0;
        @(negedge clk_24);
        bus_idle();
    endtask

    task automatic rd_status(input string name, input logic [7:0] exp);
        @(negedge clk_24);
        cpu_addr   = 16'h8B03;
        reg_cs     = 1'b1;
        cpu_mreq_n = 1'b0;
        #1 chk(name, 32'(reg_rdata), 32'(exp));
        bus_idle();
    endtask

    task automatic wait_idle(input string name, input int budget, output int cnt);
        cnt = 0;
        while (busy && cnt < budget) begin
            @(negedge clk_24);
            cnt++;
        end
        chk(name, 32'(busy), 32'(0));
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) wk_mem[i] = pat(i);
        bus_idle();
        vblank = 1'b0;
        reset  = 1'b1;

        // reset state
        repeat (2) @(negedge clk_24);
        cpu_addr = 16'h8B03;
        reg_cs   = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_wait_n", 32'(cpu_wait_n), 32'(1));
        chk("rst_spr_wr", 32'(spr_wr), 32'(0));
        chk("rst_spr_addr", 32'(spr_addr), 32'(0));
        chk("rst_spr_data", 32'(spr_data), 32'(0));
        chk("rst_status", 32'(reg_rdata), 32'(0));
        bus_idle();
        @(negedge clk_24);
        reset = 1'b0;

        // full 128-byte copy, 256 clk from start to idle
        reg_wr(2'd0, 8'h01);
        reg_wr(2'd1, 8'h00);
        reg_wr(2'd2, 8'h7F);
        push_copy(16'h0100, 127);
        reg_wr(2'd3, 8'h01);
        wait_idle("t1_idle", 600, n);
        chk("t1_cycles", 32'(n), 32'(256));

        // arm on vblank; mid-transfer vblank fall must not abort
        reg_wr(2'd0, 8'h02);
        reg_wr(2'd1, 8'h00);
        reg_wr(2'd2, 8'h04);
        reg_wr(2'd3, 8'h02);
        rd_status("t2_armed", 8'h03);
        repeat (4) @(negedge clk_24);
        push_copy(16'h0200, 4);
        vblank = 1'b1;
        @(negedge clk_24);
        chk("t2_fetch_addr", 32'(wkram_addr), 32'(16'h0200));
        chk("t2_fetch_nowr", 32'(spr_wr), 32'(0));
        repeat (3) @(negedge clk_24);
        vblank = 1'b0;
        wait_idle("t2_idle", 100, n);

        // CPU stall: ROM unstalled, wkram write held, wkram read waits then returns data
        reg_wr(2'd0, 8'h01);
        reg_wr(2'd1, 8'h00);
        reg_wr(2'd2, 8'h0F);
        push_copy(16'h0100, 15);
        reg_wr(2'd3, 8'h01);
        cpu_addr   = 16'h1234;
        cpu_mreq_n = 1'b0;
        #1;
        chk("t3_rom_wait_n", 32'(cpu_wait_n), 32'(1));
        chk("t3_dma_addr", 32'(wkram_addr), 32'(16'h0100));
        @(negedge clk_24);
        cpu_addr     = 16'hC020;
        cpu_dout     = pat(16'h0020);
        cpu_wkram_cs = 1'b1;
        cpu_wr_n     = 1'b0;
        #1;
        chk("t3_wr_wait_n", 32'(cpu_wait_n), 32'(0));
        chk("t3_wr_blocked", 32'(wkram_wr), 32'(0));
        @(negedge clk_24);
        cpu_addr = 16'hC010;
        cpu_wr_n = 1'b1;
        #1;
        chk("t3_rd_wait_n", 32'(cpu_wait_n), 32'(0));
        n = 0;
        while (!cpu_wait_n && n < 100) begin
            @(negedge clk_24);
            n++;
        end
        chk("t3_stall_len", 32'(n), 32'(30));
        chk("t3_idle_at_release", 32'(busy), 32'(0));
        @(negedge clk_24);
        chk("t3_rd_data", 32'(wkram_q), 32'(pat(16'h0010)));
        bus_idle();

        // source address wraps modulo 2**14
        reg_wr(2'd0, 8'h3F);
        reg_wr(2'd1, 8'hFE);
        reg_wr(2'd2, 8'h03);
        push_copy(16'h3FFE, 3);
        reg_wr(2'd3, 8'h01);
        wait_idle("t4_idle", 100, n);

        // GO landing on the final STORE is rejected and flags ERR; bit7 clears it
        reg_wr(2'd2, 8'h00);
        push_copy(16'h3FFE, 0);
        reg_wr(2'd3, 8'h01);
        reg_wr(2'd3, 8'h01);
        rd_status("t5_err", 8'h80);
        reg_wr(2'd3, 8'h80);
        rd_status("t5_clr", 8'h00);

        // async reset mid-transfer at idx 5
        reg_wr(2'd0, 8'h03);
        reg_wr(2'd1, 8'h00);
        reg_wr(2'd2, 8'h0F);
        push_copy(16'h0300, 15);
        reg_wr(2'd3, 8'h01);
        cpu_addr     = 16'hC010;
        cpu_wkram_cs = 1'b1;
        cpu_mreq_n   = 1'b0;
        repeat (11) @(negedge clk_24);
        chk("t6_pre_spr_addr", 32'(spr_addr), 32'(5));
        #2 reset = 1'b1;
        #1;
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_wait_n", 32'(cpu_wait_n), 32'(1));
        chk("t6_spr_wr", 32'(spr_wr), 32'(0));
        exp_q.delete();
        bus_idle();
        @(negedge clk_24);
        reset = 1'b0;
        rd_status("t6_status", 8'h00);
        push_copy(0, 0);
        reg_wr(2'd3, 8'h01);
        wait_idle("t6_idle", 100, n);

        repeat (2) @(negedge clk_24);
        chk("exp_q_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
